fft32_core: RTL and testbench
=============================

Name: fft32_core

Overview:
- Radix-2 decimation-in-time 32-point FFT on real-valued, signed fixed-point samples.
- All 32 samples arrive in parallel; all 32 complex bins leave in parallel, in natural order.
- One butterfly stage is computed per clock, using 16 parallel butterflies.
- Sits between the sample-capture logic and the spectrum consumer; out_en flags a valid spectrum.

Parameters:
- N, 16, word width of every input/output sample, two's complement.
- Q, 8, fractional bits (fixed point Q(N-Q).Q); twiddle scale = 2^Q.

Ports:
- clk2  input  1  sole clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in0_r .. in31_r  input  N each  real time-domain samples x[0..31]. Imaginary parts are implicitly 0.
- out0_r .. out31_r  output  N each  real part of bin X[0..31].
- out0_i .. out31_i  output  N each  imaginary part of bin X[0..31].
- out_en  output  1  high while outputs hold a complete, valid transform.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = LOAD, out_en = 0.
  - All internal working registers and all 64 outputs = 0.
- State machine: LOAD -> S1 -> S2 -> S3 -> S4 -> S5 -> DONE. One transition per rising edge of clk2 after rst goes high.
- LOAD:
  - Capture in0_r..in31_r into working array w[0..31] in bit-reversed index order: w[bitrev5(n)] = x[n].
  - Imaginary parts = 0.
  - Inputs are sampled only on this edge and may change afterwards.
- Stage s (1..5):
  - Span h = 2^(s-1).
  - For each pair (a, b = a + h) inside blocks of 2h, with j = a mod 2h: twiddle W = W32^(j*16/h).
  - t = w[b]*W; w[a] <= w[a] + t; w[b] <= w[a] - t.
- Twiddle ROM:
  - 16 entries, k = 0..15.
  - W32^k = round(cos(2πk/32)*2^Q) - j*round(sin(2πk/32)*2^Q).
  - Examples: k=0 -> (256,0); k=4 -> (181,-181); k=8 -> (0,-256).
- Complex multiply arithmetic:
  - Each real product is full 2N bits signed.
  - The sum of the two products is arithmetic-shifted right by Q (truncation toward -inf), then taken to N bits.
- Add/sub: N-bit two's complement, wraps on overflow (default build).
- No per-stage scaling: full gain of 32. The user keeps |x| small enough to avoid wrap.
- DONE:
  - outk_r/outk_i = w[k] (natural order).
  - out_en = 1.
  - Outputs are registered and update together on the DONE-entry edge.
  - State stays in DONE and outputs hold until the next reset; further input changes are ignored.
- Latency: out_en rises on the 6th rising edge after rst deassertion.
- Outputs stay 0 during LOAD..S5.
- Reset asserted mid-computation: immediately aborts, clears outputs and out_en. Release restarts from LOAD with the current inputs.
- New transform: pulse rst low, present new inputs no later than the first edge after release.

Optional Feature:
- Macro FFT_SAT_EN.
- Defined: every butterfly add/sub and every shifted product saturates to [-(2^(N-1)), 2^(N-1)-1] instead of wrapping.
- Undefined: plain two's-complement wrap, no saturation logic.

Test Plan:
- Impulse: in0_r=256, others 0; reset pulse -> out_en=1 on 6th edge; every outk_r=256, outk_i=0.
- DC: all inputs 256 -> out0_r=8192, out0_i=0; all other bins 0 (wrap-free since 8192 < 32767).
- Shifted impulse: in1_r=256, others 0 -> out0=(256,0), out4=(181,-181), out8=(0,-256), out16=(-256,0), out24=(0,256).
- Alternating: inputs +256/-256 by even/odd index -> out16_r=8192; all other bins 0.
- Reset mid-run: assert rst low at the 3rd edge -> outputs and out_en go 0 asynchronously. After release with new data, the correct result follows 6 edges later.
- Back-to-back: run data set 1, check it, pulse reset, apply data set 2 -> second result matches a golden FFT model. Under FFT_SAT_EN, all inputs 2000 -> out0_r=32767.

Source files
------------

// File: rtl/fft32_core.sv
// fft32_core: 32-point radix-2 DIT FFT of real samples, one 16-butterfly stage per clk2 edge (FFT_SAT_EN = saturating arithmetic).
// Latency: inputs captured on the 1st rising edge after rst release; out_en and all 64 registered outputs rise together on the 6th.
// No backpressure: the result holds in DONE until rst is pulsed; inputs are ignored except on the LOAD edge.
module fft32_core #(
    parameter int N = 16,
    parameter int Q = 8
) (
    input  logic         clk2,
    input  logic         rst,
    input  logic [N-1:0] in0_r,  in1_r,  in2_r,  in3_r,  in4_r,  in5_r,  in6_r,  in7_r,
    input  logic [N-1:0] in8_r,  in9_r,  in10_r, in11_r, in12_r, in13_r, in14_r, in15_r,
    input  logic [N-1:0] in16_r, in17_r, in18_r, in19_r, in20_r, in21_r, in22_r, in23_r,
    input  logic [N-1:0] in24_r, in25_r, in26_r, in27_r, in28_r, in29_r, in30_r, in31_r,
    output logic [N-1:0] out0_r,  out1_r,  out2_r,  out3_r,  out4_r,  out5_r,  out6_r,  out7_r,
    output logic [N-1:0] out8_r,  out9_r,  out10_r, out11_r, out12_r, out13_r, out14_r, out15_r,
    output logic [N-1:0] out16_r, out17_r, out18_r, out19_r, out20_r, out21_r, out22_r, out23_r,
    output logic [N-1:0] out24_r, out25_r, out26_r, out27_r, out28_r, out29_r, out30_r, out31_r,
    output logic [N-1:0] out0_i,  out1_i,  out2_i,  out3_i,  out4_i,  out5_i,  out6_i,  out7_i,
    output logic [N-1:0] out8_i,  out9_i,  out10_i, out11_i, out12_i, out13_i, out14_i, out15_i,
    output logic [N-1:0] out16_i, out17_i, out18_i, out19_i, out20_i, out21_i, out22_i, out23_i,
    output logic [N-1:0] out24_i, out25_i, out26_i, out27_i, out28_i, out29_i, out30_i, out31_i,
    output logic         out_en
);

    typedef enum logic [2:0] {
        ST_LOAD, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_DONE
    } state_t;

    state_t r_state, w_state_nxt;
    logic [2:0] w_stg;

    logic signed [N-1:0] w_x  [32];
    logic signed [N-1:0] r_wr [32];
    logic signed [N-1:0] r_wi [32];
    logic signed [N-1:0] r_or [32];
    logic signed [N-1:0] r_oi [32];
    logic                r_out_en;

    // butterfly operands / results, indexed by butterfly number
    logic signed [N-1:0] w_ar [16], w_ai [16], w_br [16], w_bi [16];
    logic [3:0]          w_k  [16];
    logic signed [N-1:0] w_sum_r [16], w_sum_i [16], w_dif_r [16], w_dif_i [16];
    logic signed [N-1:0] w_nr [32], w_ni [32];

    assign w_x[0]  = in0_r;  assign w_x[1]  = in1_r;  assign w_x[2]  = in2_r;  assign w_x[3]  = in3_r;
    assign w_x[4]  = in4_r;  assign w_x[5]  = in5_r;  assign w_x[6]  = in6_r;  assign w_x[7]  = in7_r;
    assign w_x[8]  = in8_r;  assign w_x[9]  = in9_r;  assign w_x[10] = in10_r; assign w_x[11] = in11_r;
    assign w_x[12] = in12_r; assign w_x[13] = in13_r; assign w_x[14] = in14_r; assign w_x[15] = in15_r;
    assign w_x[16] = in16_r; assign w_x[17] = in17_r; assign w_x[18] = in18_r; assign w_x[19] = in19_r;
    assign w_x[20] = in20_r; assign w_x[21] = in21_r; assign w_x[22] = in22_r; assign w_x[23] = in23_r;
    assign w_x[24] = in24_r; assign w_x[25] = in25_r; assign w_x[26] = in26_r; assign w_x[27] = in27_r;
    assign w_x[28] = in28_r; assign w_x[29] = in29_r; assign w_x[30] = in30_r; assign w_x[31] = in31_r;

    assign out0_r  = r_or[0];  assign out1_r  = r_or[1];  assign out2_r  = r_or[2];  assign out3_r  = r_or[3];
    assign out4_r  = r_or[4];  assign out5_r  = r_or[5];  assign out6_r  = r_or[6];  assign out7_r  = r_or[7];
    assign out8_r  = r_or[8];  assign out9_r  = r_or[9];  assign out10_r = r_or[10]; assign out11_r = r_or[11];
    assign out12_r = r_or[12]; assign out13_r = r_or[13]; assign out14_r = r_or[14]; assign out15_r = r_or[15];
    assign out16_r = r_or[16]; assign out17_r = r_or[17]; assign out18_r = r_or[18]; assign out19_r = r_or[19];
    assign out20_r = r_or[20]; assign out21_r = r_or[21]; assign out22_r = r_or[22]; assign out23_r = r_or[23];
    assign out24_r = r_or[24]; assign out25_r = r_or[25]; assign out26_r = r_or[26]; assign out27_r = r_or[27];
    assign out28_r = r_or[28]; assign out29_r = r_or[29]; assign out30_r = r_or[30]; assign out31_r = r_or[31];
    assign out0_i  = r_oi[0];  assign out1_i  = r_oi[1];  assign out2_i  = r_oi[2];  assign out3_i  = r_oi[3];
    assign out4_i  = r_oi[4];  assign out5_i  = r_oi[5];  assign out6_i  = r_oi[6];  assign out7_i  = r_oi[7];
    assign out8_i  = r_oi[8];  assign out9_i  = r_oi[9];  assign out10_i = r_oi[10]; assign out11_i = r_oi[11];
    assign out12_i = r_oi[12]; assign out13_i = r_oi[13]; assign out14_i = r_oi[14]; assign out15_i = r_oi[15];
    assign out16_i = r_oi[16]; assign out17_i = r_oi[17]; assign out18_i = r_oi[18]; assign out19_i = r_oi[19];
    assign out20_i = r_oi[20]; assign out21_i = r_oi[21]; assign out22_i = r_oi[22]; assign out23_i = r_oi[23];
    assign out24_i = r_oi[24]; assign out25_i = r_oi[25]; assign out26_i = r_oi[26]; assign out27_i = r_oi[27];
    assign out28_i = r_oi[28]; assign out29_i = r_oi[29]; assign out30_i = r_oi[30]; assign out31_i = r_oi[31];
    assign out_en  = r_out_en;

    function automatic logic [4:0] f_bitrev(input logic [4:0] v);
        return {v[0], v[1], v[2], v[3], v[4]};
    endfunction

    // Stage s (0-based) has span h=2^s; butterfly bf pairs a (upper) with a+h.
    function automatic logic [4:0] f_ia(input int s, input int bf);
        return 5'(((bf >> s) << (s + 1)) | (bf & ((1 << s) - 1)));
    endfunction

    function automatic logic [4:0] f_ib(input int s, input int bf);
        return 5'(int'(f_ia(s, bf)) + (1 << s));
    endfunction

    // twiddle exponent j*16/h, j = position inside the block
    function automatic logic [3:0] f_tk(input int s, input int bf);
        return 4'((bf & ((1 << s) - 1)) << (4 - s));
    endfunction

    // W32^k real part: round(cos(2*pi*k/32)*256); table is built for Q = 8
    function automatic logic signed [N-1:0] f_tw_re(input logic [3:0] k);
        case (k)
            4'd0:  return N'(256);  4'd1:  return N'(251);  4'd2:  return N'(237);  4'd3:  return N'(213);
            4'd4:  return N'(181);  4'd5:  return N'(142);  4'd6:  return N'(98);   4'd7:  return N'(50);
            4'd8:  return N'(0);    4'd9:  return N'(-50);  4'd10: return N'(-98);  4'd11: return N'(-142);
            4'd12: return N'(-181); 4'd13: return N'(-213); 4'd14: return N'(-237); default: return N'(-251);
        endcase
    endfunction

    // W32^k imaginary part: -round(sin(2*pi*k/32)*256)
    function automatic logic signed [N-1:0] f_tw_im(input logic [3:0] k);
        case (k)
            4'd0:  return N'(0);    4'd1:  return N'(-50);  4'd2:  return N'(-98);  4'd3:  return N'(-142);
            4'd4:  return N'(-181); 4'd5:  return N'(-213); 4'd6:  return N'(-237); 4'd7:  return N'(-251);
            4'd8:  return N'(-256); 4'd9:  return N'(-251); 4'd10: return N'(-237); 4'd11: return N'(-213);
            4'd12: return N'(-181); 4'd13: return N'(-142); 4'd14: return N'(-98);  default: return N'(-50);
        endcase
    endfunction

`ifdef FFT_SAT_EN
    localparam logic signed [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

    function automatic logic signed [N-1:0] f_sat_sum(input logic [N:0] v);
        if (v[N] != v[N-1]) return v[N] ? SAT_MIN : SAT_MAX;
        return v[N-1:0];
    endfunction

    // v is the product sum already shifted right by Q
    function automatic logic signed [N-1:0] f_sat_prod(input logic [2*N-Q:0] v);
        if ((v[2*N-Q:N-1] != '0) && (v[2*N-Q:N-1] != '1)) return v[2*N-Q] ? SAT_MIN : SAT_MAX;
        return v[N-1:0];
    endfunction
`endif

    // state register
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) r_state <= ST_LOAD;
        else      r_state <= w_state_nxt;
    end

    // next-state: straight sequence, DONE is absorbing until reset
    always_comb begin
        w_state_nxt = r_state;
        w_stg       = 3'd0;
        case (r_state)
            ST_LOAD: w_state_nxt = ST_S1;
            ST_S1:   begin w_state_nxt = ST_S2;   w_stg = 3'd0; end
            ST_S2:   begin w_state_nxt = ST_S3;   w_stg = 3'd1; end
            ST_S3:   begin w_state_nxt = ST_S4;   w_stg = 3'd2; end
            ST_S4:   begin w_state_nxt = ST_S5;   w_stg = 3'd3; end
            ST_S5:   begin w_state_nxt = ST_DONE; w_stg = 3'd4; end
            ST_DONE: w_state_nxt = ST_DONE;
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    // gather the operands of the 16 butterflies for the current stage
    always_comb begin
        for (int bf = 0; bf < 16; bf++) begin
            w_ar[bf] = '0; w_ai[bf] = '0; w_br[bf] = '0; w_bi[bf] = '0; w_k[bf] = '0;
            for (int s = 0; s < 5; s++) begin
                if (w_stg == 3'(s)) begin
                    w_ar[bf] = r_wr[f_ia(s, bf)];
                    w_ai[bf] = r_wi[f_ia(s, bf)];
                    w_br[bf] = r_wr[f_ib(s, bf)];
                    w_bi[bf] = r_wi[f_ib(s, bf)];
                    w_k[bf]  = f_tk(s, bf);
                end
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_bf
        logic signed [N-1:0]   w_cr, w_ci, w_tr, w_ti;
        logic signed [2*N-1:0] w_prr, w_pii, w_pri, w_pir;
        logic [2*N:0]          w_sr, w_si;
        logic                  w_unused_bits;

        assign w_cr  = f_tw_re(w_k[g]);
        assign w_ci  = f_tw_im(w_k[g]);
        assign w_prr = (2*N)'(w_br[g]) * (2*N)'(w_cr);
        assign w_pii = (2*N)'(w_bi[g]) * (2*N)'(w_ci);
        assign w_pri = (2*N)'(w_br[g]) * (2*N)'(w_ci);
        assign w_pir = (2*N)'(w_bi[g]) * (2*N)'(w_cr);
        // full-precision sums; dropping the low Q bits is a floor shift
        assign w_sr  = {w_prr[2*N-1], w_prr} - {w_pii[2*N-1], w_pii};
        assign w_si  = {w_pri[2*N-1], w_pri} + {w_pir[2*N-1], w_pir};
`ifdef FFT_SAT_EN
        assign w_tr  = f_sat_prod(w_sr[2*N:Q]);
        assign w_ti  = f_sat_prod(w_si[2*N:Q]);
        assign w_sum_r[g] = f_sat_sum({w_ar[g][N-1], w_ar[g]} + {w_tr[N-1], w_tr});
        assign w_sum_i[g] = f_sat_sum({w_ai[g][N-1], w_ai[g]} + {w_ti[N-1], w_ti});
        assign w_dif_r[g] = f_sat_sum({w_ar[g][N-1], w_ar[g]} - {w_tr[N-1], w_tr});
        assign w_dif_i[g] = f_sat_sum({w_ai[g][N-1], w_ai[g]} - {w_ti[N-1], w_ti});
        assign w_unused_bits = ^{w_sr[Q-1:0], w_si[Q-1:0]};
`else
        assign w_tr  = w_sr[N+Q-1:Q];
        assign w_ti  = w_si[N+Q-1:Q];
        assign w_sum_r[g] = w_ar[g] + w_tr;
        assign w_sum_i[g] = w_ai[g] + w_ti;
        assign w_dif_r[g] = w_ar[g] - w_tr;
        assign w_dif_i[g] = w_ai[g] - w_ti;
        assign w_unused_bits = ^{w_sr[2*N:N+Q], w_sr[Q-1:0], w_si[2*N:N+Q], w_si[Q-1:0]};
`endif
    end

    // scatter butterfly results back to their array positions
    always_comb begin
        for (int k = 0; k < 32; k++) begin
            w_nr[k] = r_wr[k];
            w_ni[k] = r_wi[k];
        end
        for (int s = 0; s < 5; s++) begin
            if (w_stg == 3'(s)) begin
                for (int bf = 0; bf < 16; bf++) begin
                    w_nr[f_ia(s, bf)] = w_sum_r[bf];
                    w_ni[f_ia(s, bf)] = w_sum_i[bf];
                    w_nr[f_ib(s, bf)] = w_dif_r[bf];
                    w_ni[f_ib(s, bf)] = w_dif_i[bf];
                end
            end
        end
    end

    // working array, output registers and out_en
    always_ff @(posedge clk2 or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 32; k++) begin
                r_wr[k] <= '0; r_wi[k] <= '0; r_or[k] <= '0; r_oi[k] <= '0;
            end
            r_out_en <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    for (int n = 0; n < 32; n++) begin
                        r_wr[f_bitrev(5'(n))] <= w_x[n];
                        r_wi[n] <= '0;
                    end
                end
                ST_S1, ST_S2, ST_S3, ST_S4: begin
                    for (int k = 0; k < 32; k++) begin
                        r_wr[k] <= w_nr[k]; r_wi[k] <= w_ni[k];
                    end
                end
                ST_S5: begin
                    for (int k = 0; k < 32; k++) begin
                        r_wr[k] <= w_nr[k]; r_wi[k] <= w_ni[k];
                        r_or[k] <= w_nr[k]; r_oi[k] <= w_ni[k];
                    end
                    r_out_en <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft32_core.sv
// tb_fft32_core: directed vectors for fft32_core with hand-derived spectra.
// Latency: each transform is checked 5 edges (not ready) and 6 edges (ready) after rst release.
// No backpressure: reset pulses separate transforms.
module tb_fft32_core;
    logic        clk2 = 1'b0;
    logic        rst;
    logic [15:0] in_r  [32];
    logic [15:0] out_r [32];
    logic [15:0] out_i [32];
    logic        out_en;
    int checks = 0;
    int errors = 0;
    int er, ei;

    // W32^k = cos_t[k] - j*sin_t[k], scaled by 256
    int cos_t [16] = '{256, 251, 237, 213, 181, 142, 98, 50, 0, -50, -98, -142, -181, -213, -237, -251};
    int sin_t [16] = '{0, 50, 98, 142, 181, 213, 237, 251, 256, 251, 237, 213, 181, 142, 98, 50};

    always #5 clk2 = ~clk2;

    fft32_core u_dut (
        .clk2(clk2), .rst(rst),
        .in0_r(in_r[0]),   .in1_r(in_r[1]),   .in2_r(in_r[2]),   .in3_r(in_r[3]),
        .in4_r(in_r[4]),   .in5_r(in_r[5]),   .in6_r(in_r[6]),   .in7_r(in_r[7]),
        .in8_r(in_r[8]),   .in9_r(in_r[9]),   .in10_r(in_r[10]), .in11_r(in_r[11]),
        .in12_r(in_r[12]), .in13_r(in_r[13]), .in14_r(in_r[14]), .in15_r(in_r[15]),
        .in16_r(in_r[16]), .in17_r(in_r[17]), .in18_r(in_r[18]), .in19_r(in_r[19]),
        .in20_r(in_r[20]), .in21_r(in_r[21]), .in22_r(in_r[22]), .in23_r(in_r[23]),
        .in24_r(in_r[24]), .in25_r(in_r[25]), .in26_r(in_r[26]), .in27_r(in_r[27]),
        .in28_r(in_r[28]), .in29_r(in_r[29]), .in30_r(in_r[30]), .in31_r(in_r[31]),
        .out0_r(out_r[0]),   .out1_r(out_r[1]),   .out2_r(out_r[2]),   .out3_r(out_r[3]),
        .out4_r(out_r[4]),   .out5_r(out_r[5]),   .out6_r(out_r[6]),   .out7_r(out_r[7]),
        .out8_r(out_r[8]),   .out9_r(out_r[9]),   .out10_r(out_r[10]), .out11_r(out_r[11]),
        .out12_r(out_r[12]), .out13_r(out_r[13]), .out14_r(out_r[14]), .out15_r(out_r[15]),
        .out16_r(out_r[16]), .out17_r(out_r[17]), .out18_r(out_r[18]), .out19_r(out_r[19]),
        .out20_r(out_r[20]), .out21_r(out_r[21]), .out22_r(out_r[22]), .out23_r(out_r[23]),
        .out24_r(out_r[24]), .out25_r(out_r[25]), .out26_r(out_r[26]), .out27_r(out_r[27]),
        .out28_r(out_r[28]), .out29_r(out_r[29]), .out30_r(out_r[30]), .out31_r(out_r[31]),
        .out0_i(out_i[0]),   .out1_i(out_i[1]),   .out2_i(out_i[2]),   .out3_i(out_i[3]),
        .out4_i(out_i[4]),   .out5_i(out_i[5]),   .out6_i(out_i[6]),   .out7_i(out_i[7]),
        .out8_i(out_i[8]),   .out9_i(out_i[9]),   .out10_i(out_i[10]), .out11_i(out_i[11]),
        .out12_i(out_i[12]), .out13_i(out_i[13]), .out14_i(out_i[14]), .out15_i(out_i[15]),
        .out16_i(out_i[16]), .out17_i(out_i[17]), .out18_i(out_i[18]), .out19_i(out_i[19]),
        .out20_i(out_i[20]), .out21_i(out_i[21]), .out22_i(out_i[22]), .out23_i(out_i[23]),
        .out24_i(out_i[24]), .out25_i(out_i[25]), .out26_i(out_i[26]), .out27_i(out_i[27]),
        .out28_i(out_i[28]), .out29_i(out_i[29]), .out30_i(out_i[30]), .out31_i(out_i[31]),
        .out_en(out_en)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bin(input string tag, input int k, input int exp_r, input int exp_i);
        check($sformatf("%s bin%0d_r", tag, k), int'($signed(out_r[k])), exp_r);
        check($sformatf("%s bin%0d_i", tag, k), int'($signed(out_i[k])), exp_i);
    endtask

    // W32^m for m = 0..31
    function automatic void tw(input int m, output int re, output int im);
        if (m < 16) begin
            re = cos_t[m];       im = -sin_t[m];
        end else begin
            re = -cos_t[m - 16]; im = sin_t[m - 16];
        end
    endfunction

    task automatic set_all(input int v);
        for (int k = 0; k < 32; k++) in_r[k] = 16'(v);
    endtask

    task automatic enter_reset();
        @(negedge clk2);
        rst = 1'b0;
    endtask

    // release reset, optionally scramble inputs after the capture edge, check latency
    task automatic run_fft(input string tag, input bit scramble);
        @(negedge clk2);
        rst = 1'b1;
        @(negedge clk2);
        if (scramble) for (int k = 0; k < 32; k++) in_r[k] = 16'($urandom);
        repeat (4) @(negedge clk2);
        check({tag, " out_en@5"}, int'(out_en), 0);
        check({tag, " out0_r@5"}, int'($signed(out_r[0])), 0);
        @(negedge clk2);
        check({tag, " out_en@6"}, int'(out_en), 1);
    endtask

    initial begin
        rst = 1'b0;
        set_all(0);
        @(negedge clk2);
        check("reset out_en", int'(out_en), 0);
        check("reset out0_r", int'($signed(out_r[0])), 0);
        check("reset out31_i", int'($signed(out_i[31])), 0);

        // impulse at n=0: flat spectrum
        in_r[0] = 16'd256;
        run_fft("impulse", 1'b1);
        for (int k = 0; k < 32; k++) check_bin("impulse", k, 256, 0);

        // DONE holds while inputs wander
        for (int k = 0; k < 32; k++) in_r[k] = 16'($urandom);
        repeat (3) @(negedge clk2);
        check("hold out_en", int'(out_en), 1);
        check_bin("hold", 0, 256, 0);
        check_bin("hold", 7, 256, 0);

        // asynchronous clear between clock edges
        #2 rst = 1'b0;
        #1;
        check("async out_en", int'(out_en), 0);
        check_bin("async", 0, 0, 0);
        check_bin("async", 13, 0, 0);

        // DC
        set_all(256);
        run_fft("dc", 1'b1);
        check_bin("dc", 0, 8192, 0);
        for (int k = 1; k < 32; k++) check_bin("dc", k, 0, 0);

        // impulse at n=1: X[k] = 256*W^k
        enter_reset();
        set_all(0);
        in_r[1] = 16'd256;
        run_fft("shift1", 1'b1);
        for (int k = 0; k < 32; k++) begin
            tw(k, er, ei);
            check_bin("shift1", k, er, ei);
        end

        // alternating +256/-256
        enter_reset();
        for (int k = 0; k < 32; k++) in_r[k] = (k % 2 == 0) ? 16'd256 : 16'hFF00;
        run_fft("alt", 1'b1);
        for (int k = 0; k < 32; k++) check_bin("alt", k, (k == 16) ? 8192 : 0, 0);

        // unit impulse at n=1: products floor toward -inf
        enter_reset();
        set_all(0);
        in_r[1] = 16'd1;
        run_fft("tiny", 1'b1);
        check_bin("tiny", 0, 1, 0);
        check_bin("tiny", 1, 0, -1);
        check_bin("tiny", 8, 0, -1);
        check_bin("tiny", 9, -1, -1);
        check_bin("tiny", 16, -1, 0);
        check_bin("tiny", 17, 0, 1);
        check_bin("tiny", 25, 1, 1);

        // large DC: 64000 wraps to -1536, or saturates
        enter_reset();
        set_all(2000);
        run_fft("big", 1'b1);
`ifdef FFT_SAT_EN
        check_bin("big", 0, 32767, 0);
`else
        check_bin("big", 0, -1536, 0);
`endif
        check_bin("big", 1, 0, 0);
        check_bin("big", 16, 0, 0);

        // abort at the 3rd edge, restart with new data (impulse at n=2)
        enter_reset();
        set_all(0);
        in_r[0] = 16'd256;
        in_r[1] = 16'd256;
        @(negedge clk2);
        rst = 1'b1;
        repeat (3) @(posedge clk2);
        #1 rst = 1'b0;
        set_all(0);
        in_r[2] = 16'd256;
        #1;
        check("abort out_en", int'(out_en), 0);
        check_bin("abort", 0, 0, 0);
        run_fft("restart", 1'b0);
        for (int k = 0; k < 32; k++) begin
            tw((2 * k) % 32, er, ei);
            check_bin("restart", k, er, ei);
        end

        // back-to-back second data set: x[0]=x[1]=256 -> X[k] = 256 + 256*W^k
        enter_reset();
        set_all(0);
        in_r[0] = 16'd256;
        in_r[1] = 16'd256;
        run_fft("set2", 1'b1);
        for (int k = 0; k < 32; k++) begin
            tw(k, er, ei);
            check_bin("set2", k, 256 + er, ei);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
